// File: rtl/nested_rec_skid.sv
// ============================================================================
// Module   : nested_rec_skid
// Purpose  : Registered two-entry valid/ready skid stage for a packed nested
//            record {g:{a,b}, h[H_W-1:0]}. The head record and its decoded
//            fields are presented downstream, and accepted records are
//            counted.
// Ports    : clk, rst        - clock and asynchronous active-high reset
//            in_valid/ready  - upstream handshake (in_ready is registered)
//            in_rec          - incoming record: [RW-1]=g.a [RW-2]=g.b [H_W-1:0]=h
//            out_valid/ready - downstream handshake
//            out_rec         - head record, whole
//            out_g/a/b/h     - field slices of out_rec
//            rec_cnt         - records accepted since reset (wraps)
//            in_par, out_par, par_err - only with NESTED_REC_PARITY_EN
// Config   : NESTED_REC_PARITY_EN adds per-record parity storage and a
//            sticky parity error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nested_rec_skid #(
    parameter int               H_W      = 3,
    parameter logic [H_W+1:0]   INIT_REC = {1'b1, 1'b0, 3'b111},
    parameter int               CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
`ifdef NESTED_REC_PARITY_EN
    input  logic               in_par,
    output logic               out_par,
    output logic               par_err,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [H_W+1:0]     in_rec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [H_W+1:0]     out_rec,
    output logic [1:0]         out_g,
    output logic               out_a,
    output logic               out_b,
    output logic [H_W-1:0]     out_h,
    output logic [CNT_W-1:0]   rec_cnt
);

    localparam int         c_RW    = H_W + 2;
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [c_RW-1:0]  r_head;
    logic [c_RW-1:0]  r_skid;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_state_nxt;
    logic [c_RW-1:0]  w_head_nxt;
    logic [c_RW-1:0]  w_skid_nxt;
    logic             w_acc;
    logic             w_pop;
    logic             w_valid;

`ifdef NESTED_REC_PARITY_EN
    logic r_head_par;
    logic r_skid_par;
    logic r_par_err;
    logic w_head_par_nxt;
    logic w_skid_par_nxt;
`endif

    assign w_valid = (r_state != c_EMPTY);
    assign w_acc   = in_valid & r_in_ready;
    assign w_pop   = w_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
`ifdef NESTED_REC_PARITY_EN
        w_head_par_nxt = r_head_par;
        w_skid_par_nxt = r_skid_par;
`endif
        case (r_state)
            c_EMPTY: begin
                if (w_acc) begin
                    w_head_nxt  = in_rec;
                    w_state_nxt = c_ONE;
`ifdef NESTED_REC_PARITY_EN
                    w_head_par_nxt = in_par;
`endif
                end
            end
            c_ONE: begin
                if (w_acc && w_pop) begin
                    w_head_nxt = in_rec;
`ifdef NESTED_REC_PARITY_EN
                    w_head_par_nxt = in_par;
`endif
                end else if (w_acc) begin
                    w_skid_nxt  = in_rec;
                    w_state_nxt = c_FULL;
`ifdef NESTED_REC_PARITY_EN
                    w_skid_par_nxt = in_par;
`endif
                end else if (w_pop) begin
                    // Idle head shows the init pattern rather than stale data.
                    w_head_nxt  = INIT_REC;
                    w_state_nxt = c_EMPTY;
`ifdef NESTED_REC_PARITY_EN
                    w_head_par_nxt = 1'b0;
`endif
                end
            end
            c_FULL: begin
                if (w_pop) begin
                    w_head_nxt  = r_skid;
                    w_state_nxt = c_ONE;
`ifdef NESTED_REC_PARITY_EN
                    w_head_par_nxt = r_skid_par;
`endif
                end
            end
            default: begin
                w_head_nxt  = INIT_REC;
                w_state_nxt = c_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_EMPTY;
            r_head     <= INIT_REC;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_head     <= w_head_nxt;
            r_skid     <= w_skid_nxt;
            // Ready is registered alongside the state it is derived from,
            // so no combinational path exists from out_ready to in_ready.
            r_in_ready <= (w_state_nxt != c_FULL);
            r_cnt      <= r_cnt + CNT_W'(w_acc);
        end
    end

`ifdef NESTED_REC_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_par <= 1'b0;
            r_skid_par <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            r_head_par <= w_head_par_nxt;
            r_skid_par <= w_skid_par_nxt;
            if (w_acc && ((^in_rec) != in_par))
                r_par_err <= 1'b1;
        end
    end

    assign out_par = r_head_par;
    assign par_err = r_par_err;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = w_valid;
    assign out_rec   = r_head;
    assign out_g     = r_head[c_RW-1:c_RW-2];
    assign out_a     = r_head[c_RW-1];
    assign out_b     = r_head[c_RW-2];
    assign out_h     = r_head[H_W-1:0];
    assign rec_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_nested_rec_skid.sv
// ============================================================================
// Module   : tb_nested_rec_skid
// Purpose  : Self-checking bench for nested_rec_skid. A queue holding the
//            records currently inside the stage serves as reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nested_rec_skid;

    localparam int         c_H_W  = 3;
    localparam int         c_RW   = c_H_W + 2;
    localparam int         c_CW   = 8;
    localparam logic [4:0] c_INIT = 5'b10111;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [c_RW-1:0] in_rec;
    logic            out_valid;
    logic            out_ready;
    logic [c_RW-1:0] out_rec;
    logic [1:0]      out_g;
    logic            out_a;
    logic            out_b;
    logic [c_H_W-1:0] out_h;
    logic [c_CW-1:0] rec_cnt;
    logic            in_par;
`ifdef NESTED_REC_PARITY_EN
    logic            out_par;
    logic            par_err;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    // Reference: records held in the stage, oldest first; bit 5 is parity.
    logic [5:0]      m_q[$];
    logic [c_CW-1:0] m_cnt;
    logic            m_perr;

    nested_rec_skid #(
        .H_W      (c_H_W),
        .INIT_REC (c_INIT),
        .CNT_W    (c_CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef NESTED_REC_PARITY_EN
        .in_par    (in_par),
        .out_par   (out_par),
        .par_err   (par_err),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rec    (in_rec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rec   (out_rec),
        .out_g     (out_g),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_h     (out_h),
        .rec_cnt   (rec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [4:0] e_rec;
        e_rec = (m_q.size() > 0) ? m_q[0][4:0] : c_INIT;
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("in_ready",  32'(in_ready),  32'(m_q.size() < 2));
        chk("out_rec",   32'(out_rec),   32'(e_rec));
        chk("out_g",     32'(out_g),     32'(e_rec[4:3]));
        chk("out_a",     32'(out_a),     32'(e_rec[4]));
        chk("out_b",     32'(out_b),     32'(e_rec[3]));
        chk("out_h",     32'(out_h),     32'(e_rec[2:0]));
        chk("rec_cnt",   32'(rec_cnt),   32'(m_cnt));
`ifdef NESTED_REC_PARITY_EN
        chk("out_par",   32'(out_par),   32'((m_q.size() > 0) ? m_q[0][5] : 1'b0));
        chk("par_err",   32'(par_err),   32'(m_perr));
`endif
    endtask

    // One clock cycle with the given inputs; model is advanced and checked.
    task automatic cyc(input logic v, input logic [4:0] r, input logic p, input logic ordy);
        logic acc;
        logic pop;
        in_valid  = v;
        in_rec    = r;
        in_par    = p;
        out_ready = ordy;
        acc = v && (m_q.size() < 2);
        pop = (m_q.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (pop) m_q.delete(0);
        if (acc) begin
            m_q.push_back({p, r});
            m_cnt = m_cnt + 8'd1;
            if ((^r) != p) m_perr = 1'b1;
        end
        check_all();
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt  = '0;
        m_perr = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_rec    = '0;
        in_par    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        logic [4:0] r;
        rst = 1'b1;
        model_reset();
        in_valid  = 1'b0;
        in_rec    = '0;
        in_par    = 1'b0;
        out_ready = 1'b0;

        // Reset values with no stimulus.
        do_reset();
        chk("rst_out_rec", 32'(out_rec), 32'h17);
        chk("rst_out_g",   32'(out_g),   32'h2);

        // Single record passes straight through.
        cyc(1'b1, 5'b01010, 1'b0, 1'b1);
        chk("one_valid", 32'(out_valid), 32'h1);
        chk("one_h",     32'(out_h),     32'h2);
        cyc(1'b0, 5'b00000, 1'b0, 1'b1);
        chk("one_empty", 32'(out_rec), 32'h17);
        chk("one_cnt",   32'(rec_cnt), 32'h1);

        // Back-to-back with a stalled consumer.
        do_reset();
        cyc(1'b1, 5'b00001, 1'b1, 1'b0);
        cyc(1'b1, 5'b00010, 1'b1, 1'b0);
        chk("full_ready", 32'(in_ready), 32'h0);
        cyc(1'b1, 5'b00011, 1'b0, 1'b0);
        cyc(1'b1, 5'b00011, 1'b0, 1'b0);
        chk("stall_head", 32'(out_rec), 32'h1);
        cyc(1'b1, 5'b00011, 1'b0, 1'b1);
        chk("drain_1", 32'(out_rec), 32'h2);
        cyc(1'b1, 5'b00011, 1'b0, 1'b1);
        chk("drain_2", 32'(out_rec), 32'h3);
        cyc(1'b0, 5'b00000, 1'b0, 1'b1);
        cyc(1'b0, 5'b00000, 1'b0, 1'b1);
        chk("b2b_cnt", 32'(rec_cnt), 32'h3);

        // Continuous streaming, counter wraps.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = 5'($urandom);
            cyc(1'b1, r, ^r, 1'b1);
        end
        chk("cnt300", 32'(rec_cnt), 32'd44);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = 5'($urandom);
            cyc(1'($urandom), r, ^r, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset while FULL.
        do_reset();
        cyc(1'b1, 5'b10001, 1'b0, 1'b0);
        cyc(1'b1, 5'b10010, 1'b0, 1'b0);
        chk("pre_rst_full", 32'(in_ready), 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #4;
        rst = 1'b0;
        cyc(1'b1, 5'b01100, 1'b0, 1'b0);
        cyc(1'b0, 5'b00000, 1'b0, 1'b0);
        chk("post_rst_alone", 32'(out_rec), 32'hC);
        cyc(1'b0, 5'b00000, 1'b0, 1'b1);

        // Parity: correct parity leaves the flag clear, wrong one sets it.
        do_reset();
        cyc(1'b1, 5'b00011, 1'b0, 1'b1);
        cyc(1'b0, 5'b00000, 1'b0, 1'b1);
        cyc(1'b1, 5'b00011, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 5'b00000, 1'b0, 1'b1);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Hard ceiling so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
